reorder_buffer: RTL and testbench
=================================

Name: reorder_buffer

Overview:
- In-order retirement buffer in the decode/issue → writeback → commit path.
- Receives one renamed instruction per cycle from decode/issue: pc, areg, preg from the rename allocation, and ppreg (previous mapping).
- Accepts out-of-order completion notifications from writeback.
- Retires the oldest completed entry each cycle on the commit notification. The rename table consumes that notification to clear pending bits and free ppreg.

Parameters:
- p_depth, 16, number of entries; power of two, ≥2.
- p_phys_addr_bits, 6, physical register address width.
- p_seq_num_bits, $clog2(p_depth), entry index (sequence number) width.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- alloc_val  in  1  decode presents instruction.
- alloc_rdy  out  1  buffer can accept.
- alloc_pc  in  32  instruction pc.
- alloc_areg  in  5  architectural dest (0 = none).
- alloc_preg  in  p_phys_addr_bits  new physical dest.
- alloc_ppreg  in  p_phys_addr_bits  previous mapping of areg.
- alloc_seq_num  out  p_seq_num_bits  index the accepted instruction receives (= tail).
- complete_val  in  1  writeback reports completion.
- complete_seq_num  in  p_seq_num_bits  index completing.
- commit_val  out  1  head entry retires this cycle.
- commit_pc  out  32  retiring pc.
- commit_areg  out  5  retiring areg.
- commit_preg  out  p_phys_addr_bits  retiring preg (0 if areg==0).
- commit_ppreg  out  p_phys_addr_bits  register to free (0 if areg==0).
- occupancy  out  p_seq_num_bits+1  valid entries.

Behaviour:
- Storage:
  - Circular array of p_depth entries: valid, done, pc, areg, preg, ppreg.
  - head and tail pointers are p_seq_num_bits wide, each with an extra wrap bit.
  - empty = pointers equal; full = indices equal and wrap bits differ.
- Reset (rst low, asynchronous, independent of clk):
  - head = tail = 0; all valid/done cleared; occupancy = 0.
  - commit_val = 0; alloc_rdy = 1; commit_* data = 0 (derived from cleared entry).
  - Reset mid-operation discards all in-flight entries. No commit is emitted for them.
- Allocation:
  - alloc_xfer = alloc_val & alloc_rdy; alloc_rdy = !full.
  - alloc_rdy does not count a same-cycle commit (no full bypass), so alloc_rdy has no combinational dependency on commit.
  - On alloc_xfer, the entry at tail is written with valid=1, done=0 and the fields; tail increments and wraps.
  - alloc_seq_num = tail index, combinational. It is meaningful only when alloc_rdy.
- Completion:
  - On complete_val, done is set for entry complete_seq_num if that entry is valid.
  - Completion to an invalid entry is ignored and flagged by a simulation assertion.
  - Duplicate completion is harmless.
  - Completion is visible to commit the cycle after it is registered. There is no same-cycle bypass.
- Commit (combinational from registered state, no backpressure):
  - commit_val = entry[head].valid & entry[head].done.
  - commit_pc and commit_areg come from the head entry.
  - commit_preg and commit_ppreg come from the head entry, forced to 0 when areg==0.
  - On commit_val, head clears valid and increments (wraps). At most one commit per cycle.
- Simultaneous events:
  - Allocate and commit in the same cycle: both proceed and occupancy is unchanged.
  - Allocate into the slot that head vacates in the same cycle cannot happen, because full blocks allocation.
  - Completion and commit targeting different entries in the same cycle are independent.
- occupancy = tail − head, including the wrap bit, registered.
- Latency:
  - alloc → earliest commit = 2 cycles (completion in the cycle after alloc, commit in the following cycle).
  - Throughput: 1 alloc + 1 complete + 1 commit per cycle.

Test Plan:
- Reset then idle: rst low 2 cycles → commit_val=0, alloc_rdy=1, occupancy=0, alloc_seq_num=0.
- In-order flow: alloc areg=5, preg=33, ppreg=5 (seq 0), complete seq 0 next cycle → one cycle later commit_val=1, commit_preg=33, commit_ppreg=5; occupancy back to 0.
- Out-of-order completion: alloc seq 0,1,2; complete 2, then 1, then 0 → no commit until seq 0 done, then commits 0,1,2 on three consecutive cycles.
- Full and wrap:
  - 16 allocs with no completions → alloc_rdy=0, occupancy=16.
  - Complete and commit seq 0 → alloc_rdy=1; next alloc receives seq 0 (wrapped).
  - Hold alloc_val at 0 for one cycle after commit, then alloc: occupancy=16 after that alloc, confirming that wrap-bit full/empty tracking stays correct.
- No-dest instruction: alloc areg=0, preg=7, ppreg=9, complete → commit_val=1, commit_preg=0, commit_ppreg=0.
- Async reset mid-flight: 5 entries pending, 2 done, rst asserted between clock edges → outputs reset immediately; after release no commit appears and occupancy=0.

Source files
------------

// File: rtl/reorder_buffer_if.sv
// Decode/writeback/commit bundle for the reorder buffer.
// alloc moves one entry when alloc_val && alloc_rdy on a rising edge; complete and commit are valid-only, no backpressure.
interface reorder_buffer_if #(
   parameter int p_depth          = 16,
   parameter int p_phys_addr_bits = 6,
   parameter int p_seq_num_bits   = $clog2(p_depth)
) ();
   logic                        alloc_val;
   logic                        alloc_rdy;
   logic [31:0]                 alloc_pc;
   logic [4:0]                  alloc_areg;
   logic [p_phys_addr_bits-1:0] alloc_preg;
   logic [p_phys_addr_bits-1:0] alloc_ppreg;
   logic [p_seq_num_bits-1:0]   alloc_seq_num;
   logic                        complete_val;
   logic [p_seq_num_bits-1:0]   complete_seq_num;
   logic                        commit_val;
   logic [31:0]                 commit_pc;
   logic [4:0]                  commit_areg;
   logic [p_phys_addr_bits-1:0] commit_preg;
   logic [p_phys_addr_bits-1:0] commit_ppreg;
   logic [p_seq_num_bits:0]     occupancy;

   modport master (
      output alloc_val, alloc_pc, alloc_areg, alloc_preg, alloc_ppreg,
             complete_val, complete_seq_num,
      input  alloc_rdy, alloc_seq_num, commit_val, commit_pc, commit_areg,
             commit_preg, commit_ppreg, occupancy
   );

   modport slave (
      input  alloc_val, alloc_pc, alloc_areg, alloc_preg, alloc_ppreg,
             complete_val, complete_seq_num,
      output alloc_rdy, alloc_seq_num, commit_val, commit_pc, commit_areg,
             commit_preg, commit_ppreg, occupancy
   );
endinterface

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocates in program order, accepts out-of-order
// completion, and retires the oldest completed entry once per cycle.
module reorder_buffer #(
   parameter int p_depth          = 16,
   parameter int p_phys_addr_bits = 6,
   parameter int p_seq_num_bits   = $clog2(p_depth)
) (
   input logic             clk,
   input logic             rst,
   reorder_buffer_if.slave rob
);
   typedef logic [p_seq_num_bits:0] ptr_t;

   ptr_t                        head;
   ptr_t                        tail;
   logic [p_depth-1:0]          valid;
   logic [p_depth-1:0]          done;
   logic [31:0]                 pc_mem    [p_depth];
   logic [4:0]                  areg_mem  [p_depth];
   logic [p_phys_addr_bits-1:0] preg_mem  [p_depth];
   logic [p_phys_addr_bits-1:0] ppreg_mem [p_depth];

   logic [p_seq_num_bits-1:0] head_idx;
   logic [p_seq_num_bits-1:0] tail_idx;
   logic [p_seq_num_bits-1:0] cpl_idx;
   logic                      full;
   logic                      alloc_xfer;
   logic                      commit;
   logic                      no_dest;

   assign head_idx   = head[p_seq_num_bits-1:0];
   assign tail_idx   = tail[p_seq_num_bits-1:0];
   assign cpl_idx    = rob.complete_seq_num;
   assign full       = (head_idx == tail_idx) && (head[p_seq_num_bits] != tail[p_seq_num_bits]);
   // Ready ignores a same-cycle commit so it never depends on commit timing.
   assign alloc_xfer = rob.alloc_val && !full;
   assign commit     = valid[head_idx] && done[head_idx];
   assign no_dest    = (areg_mem[head_idx] == 5'd0);

   assign rob.alloc_rdy     = !full;
   assign rob.alloc_seq_num = tail_idx;
   assign rob.occupancy     = tail - head;
   assign rob.commit_val    = commit;
   assign rob.commit_pc     = pc_mem[head_idx];
   assign rob.commit_areg   = areg_mem[head_idx];
   assign rob.commit_preg   = no_dest ? '0 : preg_mem[head_idx];
   assign rob.commit_ppreg  = no_dest ? '0 : ppreg_mem[head_idx];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head  <= '0;
         tail  <= '0;
         valid <= '0;
         done  <= '0;
         for (int i = 0; i < p_depth; i++) begin
            pc_mem[i]    <= '0;
            areg_mem[i]  <= '0;
            preg_mem[i]  <= '0;
            ppreg_mem[i] <= '0;
         end
      end else begin
         if (rob.complete_val && valid[cpl_idx]) begin
            done[cpl_idx] <= 1'b1;
         end
         // Placed after completion so a duplicate completion on the retiring entry cannot resurrect it.
         if (commit) begin
            valid[head_idx] <= 1'b0;
            done[head_idx]  <= 1'b0;
            head            <= head + ptr_t'(1);
         end
         if (alloc_xfer) begin
            valid[tail_idx]     <= 1'b1;
            done[tail_idx]      <= 1'b0;
            pc_mem[tail_idx]    <= rob.alloc_pc;
            areg_mem[tail_idx]  <= rob.alloc_areg;
            preg_mem[tail_idx]  <= rob.alloc_preg;
            ppreg_mem[tail_idx] <= rob.alloc_ppreg;
            tail                <= tail + ptr_t'(1);
         end
      end
   end

   a_complete_valid: assert property (@(posedge clk) disable iff (!rst)
      rob.complete_val |-> valid[cpl_idx]);

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed and random checks of reorder_buffer against a queue-based program-order model.
module tb_reorder_buffer;
   localparam int depth = 16;
   localparam int pb    = 6;
   localparam int sb    = 4;

   typedef struct {
      int          seq;
      logic [31:0] pc;
      logic [4:0]  areg;
      logic [5:0]  preg;
      logic [5:0]  ppreg;
      bit          done;
   } ent_t;

   logic clk = 1'b0;
   logic rst = 1'b0;

   reorder_buffer_if #(.p_depth(depth), .p_phys_addr_bits(pb)) bus ();
   reorder_buffer #(.p_depth(depth), .p_phys_addr_bits(pb)) dut (
      .clk(clk),
      .rst(rst),
      .rob(bus)
   );

   always #5 clk = ~clk;

   ent_t        m_q[$];
   logic [31:0] exp_q[$];
   int          m_tail;
   int          n_checks;
   int          n_errors;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      m_q.delete();
      exp_q.delete();
      m_tail = 0;
   endtask

   // Program-order model: oldest entry retires once it has been marked done.
   task automatic model_step();
      bit   do_commit;
      bit   do_alloc;
      ent_t e;
      do_commit = (m_q.size() > 0) && m_q[0].done;
      do_alloc  = bus.alloc_val && (m_q.size() < depth);
      if (bus.complete_val) begin
         foreach (m_q[i]) if (m_q[i].seq == int'(bus.complete_seq_num)) m_q[i].done = 1'b1;
      end
      if (do_commit) void'(m_q.pop_front());
      if (do_alloc) begin
         e.seq   = m_tail;
         e.pc    = bus.alloc_pc;
         e.areg  = bus.alloc_areg;
         e.preg  = bus.alloc_preg;
         e.ppreg = bus.alloc_ppreg;
         e.done  = 1'b0;
         m_q.push_back(e);
         exp_q.push_back(bus.alloc_pc);
         m_tail = (m_tail + 1) % depth;
      end
   endtask

   // Compare process: every falling edge while out of reset.
   always @(negedge clk) begin
      bit cv;
      if (rst) begin
         cv = (m_q.size() > 0) && m_q[0].done;
         check("commit_val", {31'd0, bus.commit_val}, {31'd0, cv});
         check("alloc_rdy", {31'd0, bus.alloc_rdy}, (m_q.size() < depth) ? 1 : 0);
         check("occupancy", 32'(bus.occupancy), m_q.size());
         check("alloc_seq_num", 32'(bus.alloc_seq_num), m_tail);
         if (cv) begin
            check("commit_pc", bus.commit_pc, m_q[0].pc);
            check("commit_areg", 32'(bus.commit_areg), 32'(m_q[0].areg));
            check("commit_preg", 32'(bus.commit_preg), (m_q[0].areg == 0) ? 0 : 32'(m_q[0].preg));
            check("commit_ppreg", 32'(bus.commit_ppreg), (m_q[0].areg == 0) ? 0 : 32'(m_q[0].ppreg));
         end
         if (bus.commit_val) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL retire_order: commit pc %0h with nothing outstanding", bus.commit_pc);
            end else begin
               check("retire_order", bus.commit_pc, exp_q.pop_front());
            end
         end
      end
   end

   task automatic cycle(bit av, logic [31:0] pc, logic [4:0] ar, logic [5:0] pr,
                        logic [5:0] pp, bit cv, int cs);
      bus.alloc_val        = av;
      bus.alloc_pc         = pc;
      bus.alloc_areg       = ar;
      bus.alloc_preg       = pr;
      bus.alloc_ppreg      = pp;
      bus.complete_val     = cv;
      bus.complete_seq_num = cs[sb-1:0];
      @(posedge clk);
      if (!rst) model_clear();
      else model_step();
      #1;
      bus.alloc_val    = 1'b0;
      bus.complete_val = 1'b0;
   endtask

   task automatic idle();
      cycle(1'b0, 32'd0, 5'd0, 6'd0, 6'd0, 1'b0, 0);
   endtask

   task automatic alloc(logic [31:0] pc, logic [4:0] ar, logic [5:0] pr, logic [5:0] pp);
      cycle(1'b1, pc, ar, pr, pp, 1'b0, 0);
   endtask

   task automatic complete(int cs);
      cycle(1'b0, 32'd0, 5'd0, 6'd0, 6'd0, 1'b1, cs);
   endtask

   task automatic do_reset();
      #2;
      rst = 1'b0;
      model_clear();
      repeat (2) @(posedge clk);
      #3;
      rst = 1'b1;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      model_clear();
      bus.alloc_val        = 1'b0;
      bus.alloc_pc         = '0;
      bus.alloc_areg       = '0;
      bus.alloc_preg       = '0;
      bus.alloc_ppreg      = '0;
      bus.complete_val     = 1'b0;
      bus.complete_seq_num = '0;

      // Reset then idle
      do_reset();
      check("rst_commit_val", {31'd0, bus.commit_val}, 0);
      check("rst_alloc_rdy", {31'd0, bus.alloc_rdy}, 1);
      check("rst_occupancy", 32'(bus.occupancy), 0);
      check("rst_seq", 32'(bus.alloc_seq_num), 0);
      check("rst_commit_pc", bus.commit_pc, 0);
      check("rst_commit_ppreg", 32'(bus.commit_ppreg), 0);

      // In-order flow
      alloc(32'h100, 5'd5, 6'd33, 6'd5);
      check("io_occ", 32'(bus.occupancy), 1);
      check("io_no_early_commit", {31'd0, bus.commit_val}, 0);
      complete(0);
      check("io_commit_val", {31'd0, bus.commit_val}, 1);
      check("io_commit_preg", 32'(bus.commit_preg), 33);
      check("io_commit_ppreg", 32'(bus.commit_ppreg), 5);
      idle();
      check("io_occ_after", 32'(bus.occupancy), 0);
      check("io_commit_val_after", {31'd0, bus.commit_val}, 0);

      // Out-of-order completion
      do_reset();
      alloc(32'h200, 5'd1, 6'd10, 6'd1);
      alloc(32'h204, 5'd2, 6'd11, 6'd2);
      alloc(32'h208, 5'd3, 6'd12, 6'd3);
      check("ooo_seq", 32'(bus.alloc_seq_num), 3);
      complete(2);
      check("ooo_wait_a", {31'd0, bus.commit_val}, 0);
      complete(1);
      check("ooo_wait_b", {31'd0, bus.commit_val}, 0);
      complete(0);
      check("ooo_c0", bus.commit_pc, 32'h200);
      idle();
      check("ooo_c1", bus.commit_pc, 32'h204);
      check("ooo_c1_val", {31'd0, bus.commit_val}, 1);
      idle();
      check("ooo_c2", bus.commit_pc, 32'h208);
      check("ooo_c2_val", {31'd0, bus.commit_val}, 1);
      idle();
      check("ooo_drained", 32'(bus.occupancy), 0);

      // Full and wrap
      do_reset();
      for (int i = 0; i < depth; i++) alloc(32'h1000 + 32'(i * 4), 5'd7, 6'(i), 6'd7);
      check("full_rdy", {31'd0, bus.alloc_rdy}, 0);
      check("full_occ", 32'(bus.occupancy), 16);
      alloc(32'hdead, 5'd7, 6'd0, 6'd0);
      check("full_ignored", 32'(bus.occupancy), 16);
      complete(0);
      check("full_commit", {31'd0, bus.commit_val}, 1);
      idle();
      check("wrap_rdy", {31'd0, bus.alloc_rdy}, 1);
      check("wrap_seq", 32'(bus.alloc_seq_num), 0);
      idle();
      alloc(32'h2000, 5'd8, 6'd40, 6'd8);
      check("wrap_occ", 32'(bus.occupancy), 16);
      check("wrap_full_again", {31'd0, bus.alloc_rdy}, 0);
      check("wrap_seq_next", 32'(bus.alloc_seq_num), 1);

      // No-dest instruction
      do_reset();
      alloc(32'h300, 5'd0, 6'd7, 6'd9);
      complete(0);
      check("nd_val", {31'd0, bus.commit_val}, 1);
      check("nd_preg", 32'(bus.commit_preg), 0);
      check("nd_ppreg", 32'(bus.commit_ppreg), 0);
      idle();

      // Async reset mid-flight
      do_reset();
      for (int i = 0; i < 5; i++) alloc(32'h400 + 32'(i * 4), 5'd3, 6'd20, 6'd3);
      complete(1);
      complete(3);
      check("ar_occ_before", 32'(bus.occupancy), 5);
      #2;
      rst = 1'b0;
      model_clear();
      #1;
      check("ar_commit_val", {31'd0, bus.commit_val}, 0);
      check("ar_rdy", {31'd0, bus.alloc_rdy}, 1);
      check("ar_occ", 32'(bus.occupancy), 0);
      check("ar_seq", 32'(bus.alloc_seq_num), 0);
      repeat (2) @(posedge clk);
      #3;
      rst = 1'b1;
      repeat (4) idle();
      check("ar_occ_after", 32'(bus.occupancy), 0);

      // Randomized traffic against the model
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         bit cv;
         int cs;
         cv = (m_q.size() > 0) && ($urandom_range(0, 9) < ((n < 1500) ? 5 : 8));
         cs = cv ? m_q[$urandom_range(0, m_q.size() - 1)].seq : 0;
         cycle($urandom_range(0, 9) < 7, $urandom, 5'($urandom_range(0, 31)),
               6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), cv, cs);
      end
      repeat (3) idle();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
